// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
//  Definitions shared by the perceptron classifier and its online trainer:
//   - N_IN / W_W : default feature count and signed weight width
//   - state_t    : trainer FSM states
//   - sat_add    : signed W_W-bit add with clamp to [-2**(W_W-1), 2**(W_W-1)-1]
//  No ports (package).
// -----------------------------------------------------------------------------
package perceptron_pkg;

  localparam int N_IN = 8;
  localparam int W_W  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CLS = 2'd1,
    UPDATE   = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Add one extra bit of headroom; a disagreement between the two top bits of
  // the widened sum means the true result left the representable range.
  function automatic logic [W_W-1:0] sat_add(input logic [W_W-1:0] a,
                                             input logic [W_W-1:0] d);
    logic [W_W:0] s;
    s = {a[W_W-1], a} + {d[W_W-1], d};
    if (s[W_W] != s[W_W-1])
      sat_add = s[W_W] ? {1'b1, {(W_W-1){1'b0}}} : {1'b0, {(W_W-1){1'b1}}};
    else
      sat_add = s[W_W-1:0];
  endfunction

endpackage

// File: rtl/perceptron_trainer_sat_step.sv
// -----------------------------------------------------------------------------
// sat_step
//  Combinational saturating step unit. Every lane adds the same signed step
//  i_d to its own signed operand and clamps the result to the W_W-bit range.
//  The trainer uses two lanes so the selected weight and the bias can both be
//  stepped in the final UPDATE cycle.
//  Ports:
//   i_a    in   LANES*W_W  packed signed operands, lane n at [n*W_W +: W_W]
//   i_d    in   W_W        signed step shared by all lanes
//   o_sum  out  LANES*W_W  packed clamped results
// -----------------------------------------------------------------------------
module sat_step #(
  parameter int W_W   = perceptron_pkg::W_W,
  parameter int LANES = 2
) (
  input  logic [LANES*W_W-1:0] i_a,
  input  logic [W_W-1:0]       i_d,
  output logic [LANES*W_W-1:0] o_sum
);

  localparam logic [W_W-1:0] SAT_MAX = {1'b0, {(W_W-1){1'b1}}};
  localparam logic [W_W-1:0] SAT_MIN = {1'b1, {(W_W-1){1'b0}}};

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W_W:0] w_raw;
      assign w_raw = {i_a[gi*W_W+W_W-1], i_a[gi*W_W +: W_W]} + {i_d[W_W-1], i_d};
      // Overflow when the sign bit and the extra headroom bit disagree.
      assign o_sum[gi*W_W +: W_W] = (w_raw[W_W] != w_raw[W_W-1])
                                    ? (w_raw[W_W] ? SAT_MIN : SAT_MAX)
                                    : w_raw[W_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/perceptron_trainer.sv
// -----------------------------------------------------------------------------
// perceptron_trainer
//  Online trainer for the perceptron classifier. Accepts one labelled sample
//  per handshake, waits (bounded) for the classifier result, and applies the
//  perceptron learning rule one weight per cycle, followed by the bias in the
//  last weight cycle. Keeps a saturating misclassification counter.
//  Ports:
//   clk        in   1          clock
//   rst_n      in   1          asynchronous active-low reset
//   train_en   in   1          1 = apply updates, 0 = classify only
//   smp_valid  in   1          sample offered
//   smp_ready  out  1          high only while idle
//   smp_x      in   N_IN       binary feature vector
//   smp_label  in   1          target class
//   cls_valid  in   1          classifier result strobe
//   cls_bit    in   1          classifier result
//   weights_o  out  N_IN*W_W   packed signed weights, w[i] at [i*W_W +: W_W]
//   bias_o     out  W_W        signed bias
//   upd_done   out  1          pulse: sample fully processed
//   timeout_o  out  1          pulse: no classifier result in time
//   err_count  out  CNT_W      saturating misclassification count
//   clr_count  in   1          synchronous clear of err_count
//  Timing: with the sample accepted on edge 0 and cls_valid sampled on edge k,
//  upd_done is high in cycle k+2 (no update) or k+N_IN+2 (update); timeout_o is
//  high in cycle TIMEOUT+1 when no result arrived during cycles 1..TIMEOUT.
// -----------------------------------------------------------------------------
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int N_IN    = perceptron_pkg::N_IN,
  parameter int W_W     = perceptron_pkg::W_W,
  parameter int LR      = 1,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                train_en,
  input  logic                smp_valid,
  output logic                smp_ready,
  input  logic [N_IN-1:0]     smp_x,
  input  logic                smp_label,
  input  logic                cls_valid,
  input  logic                cls_bit,
  output logic [N_IN*W_W-1:0] weights_o,
  output logic [W_W-1:0]      bias_o,
  output logic                upd_done,
  output logic                timeout_o,
  output logic [CNT_W-1:0]    err_count,
  input  logic                clr_count
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [W_W-1:0]   STEP_POS = W_W'(LR);
  localparam logic [W_W-1:0]   STEP_NEG = W_W'(-LR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t r_state;
  state_t w_state_next;

  logic [N_IN-1:0]  r_x;
  logic             r_label;
  logic [TMR_W-1:0] r_tmr;
  logic [IDX_W-1:0] r_idx;
  logic             r_err_neg;    // 1 when err = -1 (label 0, classified 1)
  logic [W_W-1:0]   r_bias;
  logic [CNT_W-1:0] r_cnt;
  logic             r_upd_done;
  logic             r_timeout;

  logic             w_accept;
  logic             w_cls_hit;
  logic             w_mismatch;
  logic             w_timeout_fire;
  logic             w_idx_last;
  logic             w_in_update;
  logic [W_W-1:0]   w_step;
  logic [W_W-1:0]   w_w_sel;
  logic [W_W-1:0]   w_sum_w;
  logic [W_W-1:0]   w_sum_b;
  logic [W_W-1:0]   w_w_arr [N_IN];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_cls_hit      = 1'b0;
    w_timeout_fire = 1'b0;
    w_in_update    = 1'b0;
    w_mismatch     = r_label ^ cls_bit;
    w_idx_last     = (r_idx == IDX_LAST);
    case (r_state)
      IDLE: begin
        if (smp_valid) begin
          w_accept     = 1'b1;
          w_state_next = WAIT_CLS;
        end
      end
      WAIT_CLS: begin
        // A result arriving in the last window cycle still wins over the timeout.
        if (cls_valid) begin
          w_cls_hit    = 1'b1;
          w_state_next = (w_mismatch && train_en) ? UPDATE : DONE;
        end else if (r_tmr == TMR_ONE) begin
          w_timeout_fire = 1'b1;
          w_state_next   = IDLE;
        end
      end
      UPDATE: begin
        w_in_update = 1'b1;
        if (w_idx_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign smp_ready = (r_state == IDLE);

  // ---------------------------------------------------------------------------
  // Sample holding, window timer, update index, status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_label    <= 1'b0;
      r_tmr      <= '0;
      r_idx      <= '0;
      r_err_neg  <= 1'b0;
      r_upd_done <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x     <= smp_x;
        r_label <= smp_label;
        r_tmr   <= TMR_LOAD;
      end else if (r_state == WAIT_CLS && !cls_valid) begin
        r_tmr <= r_tmr - TMR_ONE;
      end
      if (w_cls_hit) begin
        r_err_neg <= cls_bit;
        r_idx     <= '0;
      end else if (w_in_update) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      r_upd_done <= (r_state == DONE);
      r_timeout  <= w_timeout_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Misclassification counter: a clear coinciding with a miss leaves 1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_count) begin
      r_cnt <= (w_cls_hit && w_mismatch) ? CNT_ONE : '0;
    end else if (w_cls_hit && w_mismatch && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Weight/bias register file and shared saturating step
  // ---------------------------------------------------------------------------
  assign w_step  = r_err_neg ? STEP_NEG : STEP_POS;
  assign w_w_sel = w_w_arr[r_idx];

  sat_step #(
    .W_W   (W_W),
    .LANES (2)
  ) u_sat_step (
    .i_a   ({r_bias, w_w_sel}),
    .i_d   (w_step),
    .o_sum ({w_sum_b, w_sum_w})
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_w
      logic [W_W-1:0] r_w;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_w <= '0;
        else if (w_in_update && r_idx == IDX_W'(gi) && r_x[gi])
          r_w <= w_sum_w;
      end
      assign w_w_arr[gi]              = r_w;
      assign weights_o[gi*W_W +: W_W] = r_w;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bias <= '0;
    else if (w_in_update && w_idx_last)
      r_bias <= w_sum_b;
  end

  assign bias_o    = r_bias;
  assign err_count = r_cnt;
  assign upd_done  = r_upd_done;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_perceptron_trainer.sv
// -----------------------------------------------------------------------------
// tb_perceptron_trainer
//  Directed and randomized stimulus for perceptron_trainer, checked against an
//  integer model of the learning rule, clamp and counter kept in the bench.
// -----------------------------------------------------------------------------
module tb_perceptron_trainer;

  localparam int N_IN    = 8;
  localparam int W_W     = 4;
  localparam int LR      = 1;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 15;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                train_en = 1'b0;
  logic                smp_valid = 1'b0;
  logic                smp_ready;
  logic [N_IN-1:0]     smp_x = '0;
  logic                smp_label = 1'b0;
  logic                cls_valid = 1'b0;
  logic                cls_bit = 1'b0;
  logic [N_IN*W_W-1:0] weights_o;
  logic [W_W-1:0]      bias_o;
  logic                upd_done;
  logic                timeout_o;
  logic [CNT_W-1:0]    err_count;
  logic                clr_count = 1'b0;

  perceptron_trainer #(
    .N_IN(N_IN), .W_W(W_W), .LR(LR), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .train_en(train_en),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_x(smp_x),
    .smp_label(smp_label), .cls_valid(cls_valid), .cls_bit(cls_bit),
    .weights_o(weights_o), .bias_o(bias_o), .upd_done(upd_done),
    .timeout_o(timeout_o), .err_count(err_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_w [N_IN];
  int m_bias;
  int m_cnt;

  localparam int W_MIN   = -(1 << (W_W - 1));
  localparam int W_MAX   = (1 << (W_W - 1)) - 1;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  function automatic int clamp(input int v);
    if (v < W_MIN) return W_MIN;
    if (v > W_MAX) return W_MAX;
    return v;
  endfunction

  function automatic int dut_w(input int i);
    logic signed [W_W-1:0] t;
    t = weights_o[i*W_W +: W_W];
    return int'(t);
  endfunction

  function automatic int dut_bias();
    logic signed [W_W-1:0] t;
    t = bias_o;
    return int'(t);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_IN; i++) m_w[i] = 0;
    m_bias = 0;
    m_cnt  = 0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < N_IN; i++) check($sformatf("%s_w%0d", tag, i), dut_w(i), m_w[i]);
    check({tag, "_bias"}, dut_bias(), m_bias);
    check({tag, "_err_count"}, int'(err_count), m_cnt);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // One sample: offered in the current cycle, cls_valid driven in cycle k.
  task automatic run_sample(input logic [N_IN-1:0] x, input bit lab, input bit cb,
                            input int k, input bit tr, input bit clr);
    int  c;
    int  lat_exp;
    int  seen_at;
    int  e;
    bit  mism;
    check("ready_before_accept", int'(smp_ready), 1);
    smp_valid = 1'b1; smp_x = x; smp_label = lab; train_en = tr;
    nxt();
    // Scramble the sample inputs: the trainer must work from its own copy.
    smp_valid = 1'b0; smp_x = N_IN'($urandom); smp_label = 1'($urandom);
    c = 1;
    while (c < k) begin
      nxt();
      c++;
    end
    cls_valid = 1'b1; cls_bit = cb; clr_count = clr;
    nxt();
    c++;
    cls_valid = 1'b0; clr_count = 1'b0;
    train_en = 1'($urandom);  // must not disturb an update already decided
    mism    = (lab != cb);
    lat_exp = (mism && tr) ? k + N_IN + 2 : k + 2;
    seen_at = -1;
    while (c <= k + N_IN + 4) begin
      if (upd_done) begin
        seen_at = c;
        break;
      end
      nxt();
      c++;
    end
    check("upd_done_latency", seen_at, lat_exp);
    if (clr) m_cnt = 0;
    if (mism && m_cnt < CNT_TOP) m_cnt++;
    if (mism && tr) begin
      e = lab ? LR : -LR;
      for (int i = 0; i < N_IN; i++) if (x[i]) m_w[i] = clamp(m_w[i] + e);
      m_bias = clamp(m_bias + e);
    end
    check_regs("sample");
    $display("[TB] sample x=%h label=%0d cls=%0d k=%0d train=%0d clr=%0d upd_done@%0d err_count=%0d bias=%0d",
             x, lab, cb, k, tr, clr, seen_at, err_count, dut_bias());
    nxt();
    check("upd_done_pulse_width", int'(upd_done), 0);
  endtask

  initial begin
    int c;
    int seen_at;
    bit done_seen;

    model_reset();

    // ---- 1: reset ---------------------------------------------------------
    #12;
    check("rst_weights_o", (weights_o == '0) ? 1 : 0, 1);
    check("rst_bias_o", int'(bias_o), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_upd_done", int'(upd_done), 0);
    check("rst_timeout_o", int'(timeout_o), 0);
    #5 rst_n = 1'b1;
    nxt();
    check("ready_after_reset", int'(smp_ready), 1);
    $display("[TB] reset released");

    // cls_valid while idle must be ignored
    cls_valid = 1'b1; cls_bit = 1'b1;
    nxt();
    cls_valid = 1'b0;
    nxt();
    check("idle_cls_ignored_ready", int'(smp_ready), 1);
    check_regs("idle_cls_ignored");
    $display("[TB] idle cls_valid strobe");

    // ---- 2: basic update ---------------------------------------------------
    run_sample(8'h81, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    // ---- 3: correct classification, no change ------------------------------
    run_sample(8'h81, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    // ---- 4: saturation ------------------------------------------------------
    for (int r = 0; r < 10; r++) run_sample(8'h81, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    check("sat_w0_top", dut_w(0), W_MAX);
    run_sample(8'h81, 1'b0, 1'b1, 2, 1'b1, 1'b0);
    // classify-only mismatch: counted, no weight change
    run_sample(8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    // cls_valid in the very last window cycle still counts
    run_sample(8'h3C, 1'b1, 1'b0, TIMEOUT, 1'b1, 1'b0);

    // ---- 5: timeout ---------------------------------------------------------
    check("ready_before_timeout", int'(smp_ready), 1);
    smp_valid = 1'b1; smp_x = 8'hFF; smp_label = 1'b1; train_en = 1'b1;
    nxt();
    smp_valid = 1'b0;
    c = 1; seen_at = -1; done_seen = 1'b0;
    while (c <= TIMEOUT + 3) begin
      if (timeout_o) begin
        seen_at = c;
        break;
      end
      if (upd_done) done_seen = 1'b1;
      nxt();
      c++;
    end
    check("timeout_latency", seen_at, TIMEOUT + 1);
    check("timeout_ready", int'(smp_ready), 1);
    check("timeout_no_upd_done", int'(done_seen | upd_done), 0);
    // a late result after the window has closed changes nothing
    cls_valid = 1'b1; cls_bit = 1'b0;
    nxt();
    cls_valid = 1'b0;
    check("timeout_pulse_width", int'(timeout_o), 0);
    check_regs("timeout");
    $display("[TB] timeout timeout_o@%0d err_count=%0d", seen_at, err_count);
    nxt();

    // ---- 6: reset in the middle of an update (idx = 3) ---------------------
    smp_valid = 1'b1; smp_x = 8'hFF; smp_label = 1'b0; train_en = 1'b1;
    nxt();
    smp_valid = 1'b0;
    cls_valid = 1'b1; cls_bit = 1'b1;   // cycle 1
    nxt();
    cls_valid = 1'b0;                   // cycle 2: idx 0
    nxt(); nxt(); nxt();                // cycle 5: idx 3
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("mid_update_reset");
    check("mid_update_reset_ready", int'(smp_ready), 1);
    check("mid_update_reset_upd_done", int'(upd_done), 0);
    #2 rst_n = 1'b1;
    nxt();
    check("post_reset_ready", int'(smp_ready), 1);
    check_regs("post_reset");
    $display("[TB] reset mid-update");

    // clear together with a miss -> 1; clear alone -> 0
    run_sample(8'h0F, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    run_sample(8'h0F, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    run_sample(8'h0F, 1'b1, 1'b1, 1, 1'b0, 1'b1);

    // randomized samples
    for (int r = 0; r < 30; r++)
      run_sample(N_IN'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(1, TIMEOUT)), 1'($urandom), 1'($urandom_range(0, 7) == 0));

    // counter saturation
    for (int r = 0; r <= CNT_TOP; r++) run_sample(N_IN'($urandom), 1'b1, 1'b0, 1, 1'b0, 1'b0);
    check("err_count_saturated", int'(err_count), CNT_TOP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
